// File: rtl/axi_stream_packet_if.sv
// AXI4-Stream pass-through stage with a per-packet word tracker.
// Beats are forwarded combinationally; the tracker only observes accepted transfers.
module axi_stream_packet_if #(
    parameter int DATA_WIDTH       = 64,
    parameter int USER_WIDTH       = 1,
    parameter int TKEEP            = 1,
    parameter int MAX_PACKET_BYTES = 65536,
    localparam int BPW = DATA_WIDTH / 8,
    localparam int CW  = $clog2(MAX_PACKET_BYTES / BPW + 1),
    localparam int BW  = $clog2(BPW),
    localparam int WBW = $clog2(BPW + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [USER_WIDTH-1:0] s_tuser,
    input  logic [BPW-1:0]        s_tkeep,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [USER_WIDTH-1:0] m_tuser,
    output logic [BPW-1:0]        m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    input  logic [CW+BW-1:0]      query_byte,
    output logic                  reached,
    output logic [CW-1:0]         word_count,
    output logic                  sop,
    output logic [WBW-1:0]        word_bytes
);

    logic            xfer;
    logic [CW+BW-1:0] query_word;
    logic [WBW-1:0]  keep_count;
    logic [WBW-2:0]  trailing;

    assign m_tdata  = s_tdata;
    assign m_tuser  = s_tuser;
    assign m_tkeep  = s_tkeep;
    assign m_tlast  = s_tlast;
    assign m_tvalid = s_tvalid;
    assign s_tready = m_tready;

    assign xfer = s_tvalid & m_tready;

    // Saturates at all-ones so an oversized packet cannot wrap back to sop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count <= '0;
        end else if (xfer) begin
            if (s_tlast) begin
                word_count <= '0;
            end else if (word_count != '1) begin
                word_count <= word_count + CW'(1);
            end
        end
    end

    assign sop        = (word_count == '0);
    assign query_word = query_byte >> BW;
    assign reached    = ((CW+BW)'(word_count) >= query_word);
    assign trailing   = s_tuser[WBW-2:0];

    always_comb begin
        keep_count = '0;
        for (int unsigned i = 0; i < BPW; i++) begin
            keep_count = keep_count + WBW'(s_tkeep[i]);
        end
    end

    always_comb begin
        word_bytes = WBW'(BPW);
        if (s_tlast) begin
            if (TKEEP != 0) begin
                word_bytes = keep_count;
            end else if (trailing != '0) begin
                word_bytes = {1'b0, trailing};
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_packet_if.sv
// Randomised + directed bench for axi_stream_packet_if (BPW=4, both TKEEP modes).
module tb_axi_stream_packet_if;

    localparam int DW = 32;
    localparam int UW = 3;
    localparam int MAXB = 64;   // CW = 5, saturation at 31
    localparam int SAT = 31;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic [UW-1:0] s_tuser = '0;
    logic [3:0]    s_tkeep = '0;
    logic          s_tlast = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          m_tready = 1'b0;
    logic [6:0]    query_byte = '0;

    logic [DW-1:0] a_tdata, b_tdata;
    logic [UW-1:0] a_tuser, b_tuser;
    logic [3:0]    a_tkeep, b_tkeep;
    logic          a_tlast, b_tlast, a_tvalid, b_tvalid, a_tready, b_tready;
    logic          a_reached, b_reached, a_sop, b_sop;
    logic [4:0]    a_wc, b_wc;
    logic [2:0]    a_wb, b_wb;

    int checks = 0;
    int errors = 0;
    int beats = 0;

    axi_stream_packet_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .TKEEP(1), .MAX_PACKET_BYTES(MAXB)) dut_keep (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tkeep(s_tkeep),
        .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(a_tready),
        .m_tdata(a_tdata), .m_tuser(a_tuser), .m_tkeep(a_tkeep), .m_tlast(a_tlast),
        .m_tvalid(a_tvalid), .m_tready(m_tready), .query_byte(query_byte),
        .reached(a_reached), .word_count(a_wc), .sop(a_sop), .word_bytes(a_wb));

    axi_stream_packet_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .TKEEP(0), .MAX_PACKET_BYTES(MAXB)) dut_user (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tkeep(s_tkeep),
        .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(b_tready),
        .m_tdata(b_tdata), .m_tuser(b_tuser), .m_tkeep(b_tkeep), .m_tlast(b_tlast),
        .m_tvalid(b_tvalid), .m_tready(m_tready), .query_byte(query_byte),
        .reached(b_reached), .word_count(b_wc), .sop(b_sop), .word_bytes(b_wb));

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: beats accepted so far in the current packet.
    always @(posedge clk or posedge rst) begin
        if (rst) beats = 0;
        else if (s_tvalid && m_tready) beats = s_tlast ? 0 : beats + 1;
    end

    function automatic int exp_wc();
        return (beats > SAT) ? SAT : beats;
    endfunction

    function automatic int exp_bytes_keep();
        return s_tlast ? $countones(s_tkeep) : 4;
    endfunction

    function automatic int exp_bytes_user();
        if (!s_tlast) return 4;
        return (s_tuser[1:0] == 2'd0) ? 4 : int'(s_tuser[1:0]);
    endfunction

    always @(negedge clk) begin
        chk("pass_tdata_a", a_tdata, s_tdata);
        chk("pass_tdata_b", b_tdata, s_tdata);
        chk("pass_tuser_a", a_tuser, s_tuser);
        chk("pass_tuser_b", b_tuser, s_tuser);
        chk("pass_tkeep_a", a_tkeep, s_tkeep);
        chk("pass_tkeep_b", b_tkeep, s_tkeep);
        chk("pass_tlast", {a_tlast, b_tlast}, {s_tlast, s_tlast});
        chk("pass_tvalid", {a_tvalid, b_tvalid}, {s_tvalid, s_tvalid});
        chk("pass_tready", {a_tready, b_tready}, {m_tready, m_tready});
        chk("word_count_a", a_wc, exp_wc());
        chk("word_count_b", b_wc, exp_wc());
        chk("sop", {a_sop, b_sop}, {2{exp_wc() == 0}});
        chk("reached", {a_reached, b_reached}, {2{exp_wc() >= (int'(query_byte) / 4)}});
        chk("word_bytes_keep", a_wb, exp_bytes_keep());
        chk("word_bytes_user", b_wb, exp_bytes_user());
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic l, input logic r,
                         input logic [2:0] u, input logic [3:0] k);
        s_tvalid = v;
        s_tlast  = l;
        m_tready = r;
        s_tuser  = u;
        s_tkeep  = k;
        s_tdata  = $urandom;
    endtask

    initial begin
        // Reset state
        step();
        query_byte = 7'd0;
        #1 chk("rst_wc", a_wc, 0);
        chk("rst_sop", a_sop, 1);
        chk("rst_reached_q0", a_reached, 1);
        query_byte = 7'd5;
        #1 chk("rst_reached_q5", a_reached, 0);
        step();
        rst = 1'b0;
        query_byte = 7'd0;

        // 5-word packet at full throughput
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i == 4, 1'b1, 3'd0, 4'hF);
            #1 chk("seq5_wc", a_wc, i);
            chk("seq5_sop", a_sop, i == 0);
            step();
        end
        drive(1'b0, 1'b0, 1'b1, 3'd0, 4'hF);
        #1 chk("seq5_after_last", a_wc, 0);
        step();

        // 3-word packet with random stalls
        for (int i = 0, n = 0; n < 3 && i < 60; i++) begin
            drive(1'b1, n == 2, 1'($urandom_range(0, 1)), 3'd0, 4'hF);
            #1 chk("stall_wc", a_wc, n);
            if (m_tready) n++;
            step();
        end
        drive(1'b0, 1'b0, 1'b1, 3'd0, 4'hF);
        step();

        // reached with query_byte=6
        query_byte = 7'd6;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i == 2, 1'b1, 3'd0, 4'hF);
            #1 chk("q6_reached", a_reached, i != 0);
            step();
        end
        query_byte = 7'd0;
        drive(1'b0, 1'b0, 1'b1, 3'd0, 4'hF);
        #1 chk("q0_reached", a_reached, 1);
        step();

        // Last-beat byte counts (single-word packets)
        drive(1'b1, 1'b1, 1'b1, 3'b010, 4'b0111);
        #1 chk("wb_keep_0111", a_wb, 3);
        chk("wb_trailing_2", b_wb, 2);
        step();
        drive(1'b1, 1'b1, 1'b1, 3'b100, 4'b1111);
        #1 chk("wb_trailing_0", b_wb, 4);
        chk("wb_err_passes", b_tuser, 3'b100);
        step();

        // Single-word packet then 2-word packet back-to-back
        begin
            int exp_seq[4] = '{0, 0, 1, 0};
            logic last_seq[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
            for (int i = 0; i < 4; i++) begin
                drive(i != 3, last_seq[i], 1'b1, 3'd0, 4'hF);
                #1 chk("b2b_wc", a_wc, exp_seq[i]);
                step();
            end
        end

        // Reset mid-packet at word 2
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 3'd0, 4'hF);
            #1 if (i == 2) chk("pre_rst_wc", a_wc, 2);
            if (i < 2) step();
        end
        #1 rst = 1'b1;
        #1 chk("async_rst_wc", a_wc, 0);
        chk("async_rst_wc_b", b_wc, 0);
        step();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 3'd0, 4'hF);
        #1 chk("post_rst_word0", a_wc, 0);
        step();
        drive(1'b1, 1'b1, 1'b1, 3'd0, 4'hF);
        #1 chk("post_rst_word1", a_wc, 1);
        step();

        // Oversized packet saturates and holds until tlast
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b0, 1'b1, 3'd0, 4'hF);
            step();
        end
        #1 chk("sat_wc", a_wc, SAT);
        drive(1'b1, 1'b1, 1'b1, 3'd0, 4'hF);
        step();
        drive(1'b0, 1'b0, 1'b1, 3'd0, 4'hF);
        #1 chk("sat_cleared", a_wc, 0);
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic l;
            l = ($urandom_range(0, 3) == 0);
            drive(1'($urandom_range(0, 1)), l, ($urandom_range(0, 3) != 0),
                  3'($urandom), l ? (4'hF >> $urandom_range(0, 3)) : 4'hF);
            query_byte = 7'($urandom);
            step();
        end

        drive(1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
